// File: rtl/rate_seq_pkg.sv
`default_nettype none
// ============================================================================
// rate_seq_pkg : state encodings and width helper shared by the rate sequencer
// Revision     : 1.0
// ============================================================================
package rate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int c_INC_W = 8;
  localparam int c_LED_W = 8;

  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_accumulator.sv
`default_nettype none
// ============================================================================
// step_accumulator : phase accumulator with a one-cycle carry-out pulse
// Revision         : 1.0
// ============================================================================
module step_accumulator
  import rate_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [c_INC_W-1:0] increment,
  output logic [WIDTH-1:0]   count,
  output logic               carry
);

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_count} + {{(WIDTH + 1 - c_INC_W){1'b0}}, increment};

  // Carry only lives for the cycle after the add that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else if (en) begin
      r_count <= w_sum[WIDTH-1:0];
      r_carry <= w_sum[WIDTH];
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign count = r_count;
  assign carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/rate_sequencer.sv
`default_nettype none
// ============================================================================
// rate_sequencer : steps an accumulator through a table of increments,
//                  dwelling a fixed number of wraps on each entry
// Revision       : 1.0
// ============================================================================
module rate_sequencer
  import rate_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DWELL = 8,
  localparam int c_IDX_W = clog2_f(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [c_INC_W-1:0] switches,
  input  logic               load_stb,
  input  logic               run_stb,
  input  logic               pause_stb,
  input  logic               stop_stb,
  output logic [c_LED_W-1:0] led,
  output logic [1:0]         state,
  output logic [c_IDX_W-1:0] cur_idx,
  output logic               wrap
);

  localparam int                  c_DW_W       = clog2_f(DWELL + 1);
  localparam logic [c_DW_W-1:0]   c_DWELL_LAST = c_DW_W'(DWELL - 1);
  localparam logic [c_DW_W-1:0]   c_DW_ONE     = c_DW_W'(1);
  localparam logic [c_IDX_W:0]    c_NV_FULL    = (c_IDX_W + 1)'(DEPTH);
  localparam logic [c_IDX_W:0]    c_NV_ONE     = (c_IDX_W + 1)'(1);
  localparam logic [c_IDX_W-1:0]  c_IDX_ONE    = c_IDX_W'(1);

  state_e               r_state;
  logic [c_IDX_W-1:0]   r_cur_idx;
  logic [c_IDX_W-1:0]   r_wr_ptr;
  logic [c_IDX_W:0]     r_n_valid;
  logic [c_DW_W-1:0]    r_dwell;
  logic [c_INC_W-1:0]   r_table [DEPTH];

  logic [WIDTH-1:0]     w_acc;
  logic                 w_carry;
  logic                 w_acc_en;
  logic                 w_load_en;
  logic                 w_last_idx;
  logic                 w_last_dwell;
  logic [c_INC_W-1:0]   w_inc;

  // A load survives only when no higher-priority strobe shares its cycle.
  assign w_load_en    = (r_state == ST_IDLE) && load_stb && !stop_stb && !pause_stb && !run_stb;
  assign w_acc_en     = (r_state == ST_RUN) && !pause_stb && !stop_stb;
  assign w_inc        = r_table[r_cur_idx];
  assign w_last_idx   = ({1'b0, r_cur_idx} == (r_n_valid - c_NV_ONE));
  assign w_last_dwell = (r_dwell == c_DWELL_LAST);

  step_accumulator #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .en        (w_acc_en),
    .clr       (stop_stb),
    .increment (w_inc),
    .count     (w_acc),
    .carry     (w_carry)
  );

  always_ff @(posedge clk) begin
    if (w_load_en) begin
      r_table[r_wr_ptr] <= switches;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= '0;
      r_dwell   <= '0;
      r_wr_ptr  <= '0;
      r_n_valid <= '0;
    end else if (stop_stb) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= '0;
      r_dwell   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!pause_stb && run_stb && (r_n_valid != '0)) begin
            r_state   <= ST_RUN;
            r_cur_idx <= '0;
            r_dwell   <= '0;
          end
          if (w_load_en) begin
            r_wr_ptr <= r_wr_ptr + c_IDX_ONE;
            if (r_n_valid != c_NV_FULL) begin
              r_n_valid <= r_n_valid + c_NV_ONE;
            end
          end
        end
        ST_RUN: begin
          if (w_carry) begin
            if (w_last_dwell) begin
              r_dwell   <= '0;
              r_cur_idx <= w_last_idx ? '0 : r_cur_idx + c_IDX_ONE;
            end else begin
              r_dwell <= r_dwell + c_DW_ONE;
            end
          end
          if (pause_stb) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_stb) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign led     = w_acc[WIDTH-3 -: c_LED_W];
  assign state   = r_state;
  assign cur_idx = r_cur_idx;
  assign wrap    = w_carry;

endmodule
`default_nettype wire
